// File: rtl/roi_pkg.sv
// Shared types for the ROI area scheduler: FSM states, slot layout and
// the default coordinate/area width.
// Optional feature macro: ROI_AREA_THRESH_EN adds a per-slot threshold field.
package roi_pkg;

  localparam int ROI_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  typedef struct packed {
    logic [ROI_W-1:0] hl;
    logic [ROI_W-1:0] hr;
    logic [ROI_W-1:0] vl;
    logic [ROI_W-1:0] vr;
`ifdef ROI_AREA_THRESH_EN
    logic [ROI_W-1:0] thr;
`endif
  } slot_t;

endpackage

// File: rtl/roi_next_idx.sv
// Round-robin finder: the next set bit of mask strictly above cur, wrapping
// through 0 and ending at cur itself, so a lone enabled slot selects itself.
module roi_next_idx #(
  parameter int NUM_ROI = 4,
  localparam int IDX_W = $clog2(NUM_ROI)
) (
  input  logic [NUM_ROI-1:0] mask,
  input  logic [IDX_W-1:0]   cur,
  output logic [IDX_W-1:0]   nxt
);

  // Scan farthest-first so the nearest set bit after cur wins.
  always_comb begin
    nxt = cur;
    for (int k = NUM_ROI; k >= 1; k--) begin
      if (mask[(int'(cur) + k) % NUM_ROI]) begin
        nxt = IDX_W'((int'(cur) + k) % NUM_ROI);
      end
    end
  end

endmodule

// File: rtl/roi_area_sched.sv
// ROI area scheduler: time-multiplexes one area counter across NUM_ROI
// programmable windows, one window per frame in round-robin order, and
// returns one tagged area result per frame over valid/ready.
// Optional feature macro: ROI_AREA_THRESH_EN (per-slot threshold, res_hit).
module roi_area_sched
  import roi_pkg::*;
#(
  parameter int NUM_ROI = 4,
  parameter int W = ROI_W,
  localparam int IDX_W = $clog2(NUM_ROI)
) (
  input  logic               pixelclk,
  input  logic               reset,
  input  logic               i_vsync_pos,
  input  logic               i_enable,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
`ifdef ROI_AREA_THRESH_EN
  input  logic [5*W-1:0]     cfg_data,
`else
  input  logic [4*W-1:0]     cfg_data,
`endif
  input  logic [NUM_ROI-1:0] cfg_mask,
  input  logic [W-1:0]       i_area,
  output logic [W-1:0]       o_hcount_l,
  output logic [W-1:0]       o_hcount_r,
  output logic [W-1:0]       o_vcount_l,
  output logic [W-1:0]       o_vcount_r,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [IDX_W-1:0]   res_roi,
  output logic [W-1:0]       res_area,
`ifdef ROI_AREA_THRESH_EN
  output logic               res_hit,
`endif
  output logic               o_overrun,
  output logic               o_busy
);

`ifdef ROI_AREA_THRESH_EN
  localparam int CFG_TOP = 5 * W;
`else
  localparam int CFG_TOP = 4 * W;
`endif

  logic [W-1:0] hl_tab [NUM_ROI];
  logic [W-1:0] hr_tab [NUM_ROI];
  logic [W-1:0] vl_tab [NUM_ROI];
  logic [W-1:0] vr_tab [NUM_ROI];
`ifdef ROI_AREA_THRESH_EN
  logic [W-1:0] thr_tab [NUM_ROI];
`endif

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] adv_idx;
  logic [IDX_W-1:0] win_idx;
  logic             go;
  logic             win_load;
  logic             win_clr;
  logic             cap_p0;

  assign go     = i_enable && (|cfg_mask);
  assign o_busy = (state == COUNT);

  // Lowest set bit: search starting just after the top slot.
  roi_next_idx #(.NUM_ROI(NUM_ROI)) u_first (
    .mask (cfg_mask),
    .cur  (IDX_W'(NUM_ROI - 1)),
    .nxt  (first_idx)
  );

  roi_next_idx #(.NUM_ROI(NUM_ROI)) u_adv (
    .mask (cfg_mask),
    .cur  (cur),
    .nxt  (adv_idx)
  );

  // Slot table write port; addresses past the last slot are ignored.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROI; i++) begin
        hl_tab[i] <= '0;
        hr_tab[i] <= '0;
        vl_tab[i] <= '0;
        vr_tab[i] <= '0;
`ifdef ROI_AREA_THRESH_EN
        thr_tab[i] <= '0;
`endif
      end
    end else if (cfg_we && (int'(cfg_addr) < NUM_ROI)) begin
      hl_tab[cfg_addr] <= cfg_data[CFG_TOP-1     -: W];
      hr_tab[cfg_addr] <= cfg_data[CFG_TOP-1-W   -: W];
      vl_tab[cfg_addr] <= cfg_data[CFG_TOP-1-2*W -: W];
      vr_tab[cfg_addr] <= cfg_data[CFG_TOP-1-3*W -: W];
`ifdef ROI_AREA_THRESH_EN
      thr_tab[cfg_addr] <= cfg_data[W-1:0];
`endif
    end
  end

  // State register and current slot.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      if (win_load) cur <= win_idx;
    end
  end

  // Next-state, window load selection and capture strobe.
  always_comb begin
    state_nxt = state;
    win_load  = 1'b0;
    win_clr   = 1'b0;
    win_idx   = cur;
    cap_p0    = 1'b0;
    case (state)
      IDLE: begin
        win_clr = 1'b1;
        if (go) state_nxt = ARM;
      end
      ARM: begin
        if (!go) begin
          state_nxt = IDLE;
          win_clr   = 1'b1;
        end else if (i_vsync_pos) begin
          // The area at this pulse covers a partial frame and is dropped.
          state_nxt = COUNT;
          win_load  = 1'b1;
          win_idx   = first_idx;
        end
      end
      COUNT: begin
        if (!go) begin
          state_nxt = IDLE;
          win_clr   = 1'b1;
        end else if (i_vsync_pos) begin
          cap_p0   = 1'b1;
          win_load = 1'b1;
          win_idx  = adv_idx;
        end
      end
      default: begin
        state_nxt = IDLE;
        win_clr   = 1'b1;
      end
    endcase
  end

  // Window outputs: snapshot of the loaded slot, zero while not scheduling.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      o_hcount_l <= '0;
      o_hcount_r <= '0;
      o_vcount_l <= '0;
      o_vcount_r <= '0;
    end else if (win_clr) begin
      o_hcount_l <= '0;
      o_hcount_r <= '0;
      o_vcount_l <= '0;
      o_vcount_r <= '0;
    end else if (win_load) begin
      o_hcount_l <= hl_tab[win_idx];
      o_hcount_r <= hr_tab[win_idx];
      o_vcount_l <= vl_tab[win_idx];
      o_vcount_r <= vr_tab[win_idx];
    end
  end

  // Result register: load when free or being drained, otherwise flag overrun.
  always_ff @(posedge pixelclk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_roi   <= '0;
      res_area  <= '0;
      o_overrun <= 1'b0;
`ifdef ROI_AREA_THRESH_EN
      res_hit   <= 1'b0;
`endif
    end else if (cap_p0) begin
      if (!res_valid || res_ready) begin
        res_valid <= 1'b1;
        res_roi   <= cur;
        res_area  <= i_area;
`ifdef ROI_AREA_THRESH_EN
        res_hit   <= (i_area >= thr_tab[cur]);
`endif
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_roi_area_sched.sv
// Directed self-checking bench for roi_area_sched (default NUM_ROI=4, W=12).
// Optional feature macro: ROI_AREA_THRESH_EN enables the threshold checks.
`ifdef ROI_AREA_THRESH_EN
`define THR(t) , 12'(t)
`else
`define THR(t)
`endif

module tb_roi_area_sched;

  localparam int NUM_ROI = 4;
  localparam int W = 12;
  localparam int IDX_W = 2;
`ifdef ROI_AREA_THRESH_EN
  localparam int CFG_W = 5 * W;
`else
  localparam int CFG_W = 4 * W;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               vsync;
  logic               enable;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_addr;
  logic [CFG_W-1:0]   cfg_data;
  logic [NUM_ROI-1:0] cfg_mask;
  logic [W-1:0]       area;
  logic [W-1:0]       hl, hr, vl, vr;
  logic               res_valid;
  logic               res_ready;
  logic [IDX_W-1:0]   res_roi;
  logic [W-1:0]       res_area;
`ifdef ROI_AREA_THRESH_EN
  logic               res_hit;
`endif
  logic               overrun;
  logic               busy;

  int checks = 0;
  int failures = 0;

  roi_area_sched #(.NUM_ROI(NUM_ROI), .W(W)) dut (
    .pixelclk    (clk),
    .reset       (reset),
    .i_vsync_pos (vsync),
    .i_enable    (enable),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_mask    (cfg_mask),
    .i_area      (area),
    .o_hcount_l  (hl),
    .o_hcount_r  (hr),
    .o_vcount_l  (vl),
    .o_vcount_r  (vr),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_roi     (res_roi),
    .res_area    (res_area),
`ifdef ROI_AREA_THRESH_EN
    .res_hit     (res_hit),
`endif
    .o_overrun   (overrun),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_hl"}, 32'(hl), 32'(a));
    check({tag, "_hr"}, 32'(hr), 32'(b));
    check({tag, "_vl"}, 32'(vl), 32'(c));
    check({tag, "_vr"}, 32'(vr), 32'(d));
  endtask

  task automatic chk_res(input string tag, input int v, input int roi, input int ar);
    check({tag, "_valid"}, 32'(res_valid), 32'(v));
    check({tag, "_roi"}, 32'(res_roi), 32'(roi));
    check({tag, "_area"}, 32'(res_area), 32'(ar));
  endtask

  task automatic write_slot(input int idx, input logic [CFG_W-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(idx);
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse(input int a);
    area  = W'(a);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; enable = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; cfg_mask = '0; area = '0; res_ready = 1'b0;
    tick(); tick();
    chk_win("rst_win", 0, 0, 0, 0);
    chk_res("rst_res", 0, 0, 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();

    // Program slots 0 and 2, start scheduling over mask 0101.
    write_slot(0, {12'd10, 12'd50, 12'd20, 12'd60 `THR(150)});
    write_slot(2, {12'd5, 12'd6, 12'd7, 12'd8 `THR(0)});
    cfg_mask = 4'b0101; enable = 1'b1; res_ready = 1'b1;
    tick();
    check("arm_busy", 32'(busy), 0);
    chk_win("idle_win", 0, 0, 0, 0);
    pulse(999);
    check("count_busy", 32'(busy), 1);
    chk_win("arm_win", 10, 50, 20, 60);
    check("partial_discard", 32'(res_valid), 0);
    tick(); tick();
    pulse(100);
    chk_res("r1", 1, 0, 100);
    chk_win("win_slot2", 5, 6, 7, 8);
    tick();
    check("r1_drain", 32'(res_valid), 0);
    pulse(200);
    chk_res("r2", 1, 2, 200);
    chk_win("win_slot0", 10, 50, 20, 60);
    tick();
    pulse(300);
    chk_res("r3", 1, 0, 300);
    tick();

    // Backpressure across two captures.
    res_ready = 1'b0;
    pulse(400);
    chk_res("bp1", 1, 2, 400);
    check("bp1_overrun", 32'(overrun), 0);
    tick();
    pulse(500);
    chk_res("bp2_held", 1, 2, 400);
    check("bp2_overrun", 32'(overrun), 1);
    res_ready = 1'b1;
    tick();
    check("bp_drain", 32'(res_valid), 0);
    tick();
    check("overrun_sticky", 32'(overrun), 1);

    // Disable mid-COUNT, then re-enable.
    enable = 1'b0;
    tick();
    check("dis_busy", 32'(busy), 0);
    chk_win("dis_win", 0, 0, 0, 0);
    check("dis_nores", 32'(res_valid), 0);
    enable = 1'b1;
    tick(); tick();
    check("reen_wait", 32'(busy), 0);
    pulse(77);
    check("reen_busy", 32'(busy), 1);
    check("reen_nores", 32'(res_valid), 0);
    chk_win("reen_win", 10, 50, 20, 60);
    res_ready = 1'b0;
    tick();
    pulse(88);
    chk_res("pend", 1, 0, 88);

    // Asynchronous reset with a pending result, checked before any edge.
    reset = 1'b1;
    #1;
    chk_win("arst_win", 0, 0, 0, 0);
    chk_res("arst_res", 0, 0, 0);
    check("arst_overrun", 32'(overrun), 0);
    check("arst_busy", 32'(busy), 0);
    tick();
    reset = 1'b0;
    enable = 1'b0;
    tick();

    // Capture coinciding with a handshake.
    write_slot(0, {12'd10, 12'd50, 12'd20, 12'd60 `THR(150)});
    write_slot(2, {12'd5, 12'd6, 12'd7, 12'd8 `THR(0)});
    cfg_mask = 4'b0101; enable = 1'b1; res_ready = 1'b0;
    tick();
    pulse(5);
    tick();
    pulse(10);
    chk_res("seam1", 1, 0, 10);
    res_ready = 1'b1;
    pulse(20);
    chk_res("seam2", 1, 2, 20);
    check("seam_overrun", 32'(overrun), 0);
    tick();
    check("seam_drain", 32'(res_valid), 0);

    // Slot 0 masked off during its own frame; slot 2 then repeats alone.
    cfg_mask = 4'b0100;
    pulse(30);
    chk_res("mask_cur", 1, 0, 30);
    chk_win("mask_win", 5, 6, 7, 8);
    tick();
    pulse(40);
    chk_res("single1", 1, 2, 40);
    tick();
    pulse(50);
    chk_res("single2", 1, 2, 50);
    chk_win("single_win", 5, 6, 7, 8);
    tick();

`ifdef ROI_AREA_THRESH_EN
    cfg_mask = 4'b0001;
    pulse(150);
    chk_res("thr_s2", 1, 2, 150);
    check("thr_s2_hit", 32'(res_hit), 1);
    tick();
    pulse(150);
    chk_res("thr_eq", 1, 0, 150);
    check("thr_eq_hit", 32'(res_hit), 1);
    tick();
    pulse(149);
    chk_res("thr_below", 1, 0, 149);
    check("thr_below_hit", 32'(res_hit), 0);
    tick();
`endif

    // Empty mask returns to IDLE.
    cfg_mask = 4'b0000;
    tick();
    check("nomask_busy", 32'(busy), 0);
    chk_win("nomask_win", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/roi_area_sched.md
Name: roi_area_sched

Overview:
- Time-multiplexes the single area counter across up to NUM_ROI programmable regions of interest, one ROI per frame, in round-robin order.
- Drives the counter's window bounds and snapshots its total at each frame start.
- Returns one tagged result per frame over a valid/ready handshake.
- Sits between the config register bank and the target-detection logic, alongside the area counter on the pixel clock.

Parameters:
- NUM_ROI, 4, number of ROI slots (2..16).
- W, 12, coordinate and area width.
- IDX_W, $clog2(NUM_ROI), ROI index width (derived, not overridden).

Ports:
- pixelclk  in  1  pixel clock; sole clock.
- reset  in  1  asynchronous, active-high reset.
- i_vsync_pos  in  1  one-cycle frame-start pulse, shared with the area counter.
- i_enable  in  1  scheduler run enable.
- cfg_we  in  1  ROI slot write strobe.
- cfg_addr  in  IDX_W  slot index.
- cfg_data  in  4*W  {hl, hr, vl, vr}, MSB first.
- cfg_mask  in  NUM_ROI  per-slot enable.
- i_area  in  W  area counter output.
- o_hcount_l, o_hcount_r, o_vcount_l, o_vcount_r  out  W each  window to the counter.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accept.
- res_roi  out  IDX_W  slot the result belongs to.
- res_area  out  W  captured area.
- o_overrun  out  1  sticky: a result was dropped.
- o_busy  out  1  state is COUNT.

Behaviour:
- Reset values: all window outputs 0; res_valid 0; res_roi 0; res_area 0; o_overrun 0; o_busy 0; slot table all 0; state IDLE.
- Slot table: cfg_we writes slot cfg_addr on the same edge. A write to the slot currently being counted has no effect on the window outputs until that slot is next loaded.
- FSM:
  - IDLE: window outputs forced to 0. The counter uses strict inequalities, so a zero window counts nothing. If i_enable=1 and cfg_mask has any bit set -> ARM.
  - ARM: wait for i_vsync_pos. On the pulse, load cur = lowest set mask bit, register that slot onto the window outputs (visible on the next cycle), discard i_area (partial frame) -> COUNT.
  - COUNT: on i_vsync_pos, capture i_area (the counter's pre-clear value in that same cycle) as the result for cur. Then advance cur to the next set mask bit above cur, wrapping to 0. Load the new window next cycle and stay in COUNT.
- Any state: i_enable=0 or cfg_mask=0 -> IDLE on the next edge with no capture. A pending result is kept until accepted.
- Mask bit of cur cleared mid-frame: the frame completes and is reported; advance skips that slot from then on.
- Single enabled slot: the same slot repeats every frame.
- Result register:
  - Capture with res_valid=0, or with res_valid=1 and res_ready=1 in the same cycle: load it, res_valid=1.
  - Capture with res_valid=1 and res_ready=0: new result dropped, old result held, o_overrun set.
  - res_valid falls the cycle after res_valid & res_ready when there is no capture.
- o_overrun is sticky until reset.
- Latency: result visible 1 cycle after the i_vsync_pos that ends its frame; window change 1 cycle after i_vsync_pos.
- No arithmetic beyond index advance. The area width is inherited from the counter, which wraps modulo 2^W; the scheduler does not saturate.

Optional Feature:
- ROI_AREA_THRESH_EN:
  - Defined: each slot gains a W-bit threshold field; cfg_data widens to 5*W with the threshold in the LSBs.
  - Adds output res_hit, registered with the result: 1 when captured area >= threshold.
  - Undefined: no threshold storage, no res_hit port, cfg_data stays 4*W.

Decomposition:
- Shared package roi_pkg: state enum (IDLE, ARM, COUNT), slot struct {hl, hr, vl, vr[, thr]}, width constant W.
- Natural sub-module: roi_next_idx, combinational round-robin "next set bit above cur, wrap" finder over cfg_mask.

Test Plan:
1. Slots 0,2 programmed, mask=0101, enable=1, 4 vsync pulses with the counter returning 100, 200, 300 -> results (roi0,100) after pulse 2, (roi2,200) after pulse 3, (roi0,300) after pulse 4. The first partial frame is discarded.
2. Windows: slot0={10,50,20,60}. One cycle after the arming vsync, window outputs = 10,50,20,60; in IDLE they read 0.
3. res_ready held 0 across two captures -> first result held, o_overrun=1. Assert res_ready -> one handshake, res_valid drops.
4. Capture coincides with res_valid & res_ready -> new result loaded seamlessly, o_overrun stays 0.
5. i_enable dropped mid-COUNT -> IDLE next cycle, windows 0, no result. Re-enable -> ARM, waits for vsync.
6. Reset asserted while in COUNT with a pending result -> all outputs return to reset values asynchronously; with ROI_AREA_THRESH_EN, threshold 150, area 150 -> res_hit=1, area 149 -> res_hit=0.
